// File: rtl/chip8_mem_subsys_pkg.sv
// Shared definitions for the CHIP-8 memory subsystem: memory map, font ROM
// contents and the sprite-draw FSM state encoding.
package chip8_mem_subsys_pkg;

  localparam logic [11:0] REG_BASE    = 12'h020;
  localparam logic [11:0] FONT_BASE   = 12'h030;
  localparam logic [11:0] FONT_LAST   = 12'h07F;
  localparam logic [11:0] SCREEN_BASE = 12'h100;
  localparam logic [11:0] PROG_BASE   = 12'h200;

  // Standard CHIP-8 hex glyphs, 5 bytes per digit, digit d at FONT_BASE + 5*d.
  localparam logic [0:79][7:0] FONT = {
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_SPR,
    ST_READ_L,
    ST_WRITE_L,
    ST_READ_R,
    ST_WRITE_R
  } draw_state_t;

  // Glyph byte for an address already known to lie in FONT_BASE..FONT_LAST.
  function automatic logic [7:0] font_lookup(input logic [11:0] idx);
    return FONT[7'(idx - FONT_BASE)];
  endfunction

endpackage

// File: rtl/chip8_sprite_engine.sv
// Sprite-draw FSM: XORs a sprite into the in-memory framebuffer through its
// own read/write master port and accumulates the collision flag.
// Read handshake: rd_req is high for exactly one cycle; rd_ack is high in the
// following cycle with rd_byte valid. Writes take effect at the edge where
// wr_en is high. The FSM state is the register `state`.
module chip8_sprite_engine
  import chip8_mem_subsys_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        draw,
  input  logic [11:0] addr,
  input  logic [3:0]  lines,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  output logic        busy,
  output logic        collision,
  output logic        rd_req,
  output logic [11:0] rd_idx,
  input  logic        rd_ack,
  input  logic [7:0]  rd_byte,
  output logic        wr_en,
  output logic [11:0] wr_idx,
  output logic [7:0]  wr_byte
);

  draw_state_t state;
  logic [11:0] base;
  logic [3:0]  n_lines;
  logic [3:0]  line_i;
  logic [2:0]  col;
  logic [2:0]  shift;
  logic [4:0]  y0;
  logic [7:0]  spr;

  logic [4:0]  row;
  logic [11:0] left_idx;
  logic [11:0] right_idx;
  logic [15:0] wide;
  logic [7:0]  pat_l;
  logic [7:0]  pat_r;
  logic        last_line;
  logic [11:0] next_fetch;

  // Screen addresses and split sprite pattern for the current line; the
  // 16-bit shift places the left-byte part in [15:8] and the wrapped part in [7:0].
  always_comb begin
    row        = y0 + {1'b0, line_i};
    left_idx   = SCREEN_BASE | {4'h0, row, col};
    right_idx  = SCREEN_BASE | {4'h0, row, col + 3'd1};
    wide       = {spr, 8'h00} >> shift;
    pat_l      = wide[15:8];
    pat_r      = wide[7:0];
    last_line  = (line_i + 4'd1) == n_lines;
    next_fetch = base + {8'h00, line_i + 4'd1};
  end

  // Draw sequencer with registered memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      collision <= 1'b0;
      rd_req    <= 1'b0;
      rd_idx    <= '0;
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      wr_byte   <= '0;
      base      <= '0;
      n_lines   <= '0;
      line_i    <= '0;
      col       <= '0;
      shift     <= '0;
      y0        <= '0;
      spr       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (draw) begin
            base      <= addr;
            n_lines   <= lines;
            line_i    <= '0;
            col       <= x[5:3];
            shift     <= x[2:0];
            y0        <= y;
            collision <= 1'b0;
            busy      <= 1'b1;
            rd_req    <= (lines != 4'd0);
            rd_idx    <= addr;
            state     <= ST_FETCH_SPR;
          end
        end
        ST_FETCH_SPR: begin
          if (n_lines == 4'd0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (rd_req) begin
            rd_req <= 1'b0;
          end else if (rd_ack) begin
            spr    <= rd_byte;
            rd_req <= 1'b1;
            rd_idx <= left_idx;
            state  <= ST_READ_L;
          end
        end
        ST_READ_L, ST_READ_R: begin
          if (rd_req) begin
            rd_req <= 1'b0;
          end else if (rd_ack) begin
            wr_en <= 1'b1;
            if (state == ST_READ_L) begin
              wr_idx  <= left_idx;
              wr_byte <= rd_byte ^ pat_l;
              if ((rd_byte & pat_l) != 8'h00) collision <= 1'b1;
              state   <= ST_WRITE_L;
            end else begin
              wr_idx  <= right_idx;
              wr_byte <= rd_byte ^ pat_r;
              if ((rd_byte & pat_r) != 8'h00) collision <= 1'b1;
              state   <= ST_WRITE_R;
            end
          end
        end
        ST_WRITE_L, ST_WRITE_R: begin
          wr_en <= 1'b0;
          if (state == ST_WRITE_L && shift != 3'd0) begin
            rd_req <= 1'b1;
            rd_idx <= right_idx;
            state  <= ST_READ_R;
          end else if (last_line) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            line_i <= line_i + 4'd1;
            rd_req <= 1'b1;
            rd_idx <= next_fetch;
            state  <= ST_FETCH_SPR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/chip8_mem_subsys.sv
// CHIP-8 memory subsystem: 4 KiB RAM with font ROM overlay, memory-owner
// mux between the sequencer port and the sprite engine, and binary-to-BCD.
// External read handshake: mem_read sampled at an edge gives mem_read_ack=1
// for the next cycle; mem_read_byte holds until the next accepted read.
module chip8_mem_subsys
  import chip8_mem_subsys_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic [11:0] mem_read_idx,
  output logic [7:0]  mem_read_byte,
  output logic        mem_read_ack,
  input  logic        mem_write,
  input  logic [11:0] mem_write_idx,
  input  logic [7:0]  mem_write_byte,
  input  logic        draw,
  input  logic [11:0] addr,
  input  logic [3:0]  lines,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  output logic        busy,
  output logic        collision,
  input  logic [7:0]  bcd_in,
  output logic [1:0]  bcd_1,
  output logic [3:0]  bcd_2,
  output logic [3:0]  bcd_3
);

  logic [7:0]  mem [0:4095];

  logic        eng_rd_req;
  logic [11:0] eng_rd_idx;
  logic        eng_ack;
  logic [7:0]  eng_byte;
  logic        eng_wr_en;
  logic [11:0] eng_wr_idx;
  logic [7:0]  eng_wr_byte;

  logic        eng_owns;
  logic        ext_rd;
  logic        ram_we;
  logic [11:0] ram_widx;
  logic [7:0]  ram_wbyte;
  logic [11:0] ram_ridx;
  logic [7:0]  ram_rdata;
  logic [17:0] dd;

  chip8_sprite_engine u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .draw      (draw),
    .addr      (addr),
    .lines     (lines),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .collision (collision),
    .rd_req    (eng_rd_req),
    .rd_idx    (eng_rd_idx),
    .rd_ack    (eng_ack),
    .rd_byte   (eng_byte),
    .wr_en     (eng_wr_en),
    .wr_idx    (eng_wr_idx),
    .wr_byte   (eng_wr_byte)
  );

  // Owner mux: the engine holds the RAM from the draw edge until busy drops;
  // sequencer accesses in that window are dropped. The font region is served
  // by the ROM table so the glyphs exist from configuration onward.
  always_comb begin
    eng_owns  = busy | draw;
    ext_rd    = mem_read & ~eng_owns;
    ram_we    = eng_owns ? eng_wr_en   : mem_write;
    ram_widx  = eng_owns ? eng_wr_idx  : mem_write_idx;
    ram_wbyte = eng_owns ? eng_wr_byte : mem_write_byte;
    ram_ridx  = eng_owns ? eng_rd_idx  : mem_read_idx;
    if (ram_ridx >= FONT_BASE && ram_ridx <= FONT_LAST) ram_rdata = font_lookup(ram_ridx);
    else                                                ram_rdata = mem[ram_ridx];
  end

  // RAM array write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_widx] <= ram_wbyte;
  end

  // Registered read data/ack, kept separately for each master so engine
  // reads never disturb the sequencer's held read byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_ack  <= 1'b0;
      mem_read_byte <= '0;
      eng_ack       <= 1'b0;
      eng_byte      <= '0;
    end else begin
      mem_read_ack <= ext_rd;
      if (ext_rd) mem_read_byte <= ram_rdata;
      eng_ack <= eng_rd_req;
      if (eng_rd_req) eng_byte <= ram_rdata;
    end
  end

  // Binary to BCD by shift-and-add-3; result lands in dd[17:8].
  always_comb begin
    dd = {10'd0, bcd_in};
    for (int i = 0; i < 8; i++) begin
      if (dd[11:8]  >= 4'd5) dd[11:8]  = dd[11:8]  + 4'd3;
      if (dd[15:12] >= 4'd5) dd[15:12] = dd[15:12] + 4'd3;
      dd = dd << 1;
    end
    bcd_1 = dd[17:16];
    bcd_2 = dd[15:12];
    bcd_3 = dd[11:8];
  end

endmodule

// File: tb/tb_chip8_mem_subsys.sv
// Bench for chip8_mem_subsys: directed stimulus, read and draw results
// checked by a negedge monitor against expected queues.
module tb_chip8_mem_subsys;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic [11:0] mem_read_idx = '0;
  logic [7:0]  mem_read_byte;
  logic        mem_read_ack;
  logic        mem_write = 1'b0;
  logic [11:0] mem_write_idx = '0;
  logic [7:0]  mem_write_byte = '0;
  logic        draw = 1'b0;
  logic [11:0] addr = '0;
  logic [3:0]  lines = '0;
  logic [5:0]  x = '0;
  logic [4:0]  y = '0;
  logic        busy;
  logic        collision;
  logic [7:0]  bcd_in = '0;
  logic [1:0]  bcd_1;
  logic [3:0]  bcd_2;
  logic [3:0]  bcd_3;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [0:0] coll_q[$];
  int         dur_q[$];

  chip8_mem_subsys dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read       (mem_read),
    .mem_read_idx   (mem_read_idx),
    .mem_read_byte  (mem_read_byte),
    .mem_read_ack   (mem_read_ack),
    .mem_write      (mem_write),
    .mem_write_idx  (mem_write_idx),
    .mem_write_byte (mem_write_byte),
    .draw           (draw),
    .addr           (addr),
    .lines          (lines),
    .x              (x),
    .y              (y),
    .busy           (busy),
    .collision      (collision),
    .bcd_in         (bcd_in),
    .bcd_1          (bcd_1),
    .bcd_2          (bcd_2),
    .bcd_3          (bcd_3)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [11:0] a, input logic [7:0] d);
    mem_write      = 1'b1;
    mem_write_idx  = a;
    mem_write_byte = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic read_mem(input logic [11:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    mem_read     = 1'b1;
    mem_read_idx = a;
    tick();
    mem_read = 1'b0;
    check("read_ack_latency", {31'd0, mem_read_ack}, 32'd1);
    tick();
    check("read_ack_drop", {31'd0, mem_read_ack}, 32'd0);
  endtask

  task automatic start_draw(input logic [11:0] a, input logic [3:0] l,
                            input logic [5:0] xx, input logic [4:0] yy);
    draw  = 1'b1;
    addr  = a;
    lines = l;
    x     = xx;
    y     = yy;
    tick();
    draw = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL draw_timeout: busy=1 after 300 cycles, expected 0");
    end
  endtask

  task automatic run_draw(input logic [11:0] a, input logic [3:0] l,
                          input logic [5:0] xx, input logic [4:0] yy,
                          input logic ec, input int ed);
    coll_q.push_back(ec);
    dur_q.push_back(ed);
    start_draw(a, l, xx, yy);
    check("busy_rise", {31'd0, busy}, 32'd1);
    wait_idle();
  endtask

  // ---------------- scoreboard monitor ----------------
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    logic [0:0] ec;
    int         ed;
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (mem_read_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack with byte 0x%0h, expected no ack", mem_read_byte);
        end else begin
          e = exp_q.pop_front();
          check("read_data", {24'd0, mem_read_byte}, {24'd0, e});
        end
      end
      if (busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (coll_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_draw_end: busy fell after %0d cycles, expected no draw", busy_cnt);
        end else begin
          ec = coll_q.pop_front();
          ed = dur_q.pop_front();
          check("collision", {31'd0, collision}, {31'd0, ec});
          check("busy_cycles", busy_cnt, ed);
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_collision", {31'd0, collision}, 32'd0);
    check("rst_ack", {31'd0, mem_read_ack}, 32'd0);
    check("rst_byte", {24'd0, mem_read_byte}, 32'd0);
    rst_n = 1'b1;
    tick();

    // BCD directed, then exhaustive against a div/mod model
    bcd_in = 8'd0;   #1; check("bcd_0",   {22'd0, bcd_1, bcd_2, bcd_3}, {22'd0, 2'd0, 4'd0, 4'd0});
    bcd_in = 8'd109; #1; check("bcd_109", {22'd0, bcd_1, bcd_2, bcd_3}, {22'd0, 2'd1, 4'd0, 4'd9});
    bcd_in = 8'd255; #1; check("bcd_255", {22'd0, bcd_1, bcd_2, bcd_3}, {22'd0, 2'd2, 4'd5, 4'd5});
    for (int v = 0; v < 256; v++) begin
      int h, t, o;
      bcd_in = v[7:0];
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      #1;
      check("bcd_sweep", {22'd0, bcd_1, bcd_2, bcd_3}, {22'd0, h[1:0], t[3:0], o[3:0]});
    end

    // basic write/read and font contents
    write_mem(12'h300, 8'hA5);
    read_mem(12'h300, 8'hA5);
    read_mem(12'h030, 8'hF0);
    read_mem(12'h035, 8'h20);
    read_mem(12'h07F, 8'h80);

    // same-cycle read and write of one address returns old data
    write_mem(12'h301, 8'h11);
    exp_q.push_back(8'h11);
    mem_write = 1'b1; mem_write_idx = 12'h301; mem_write_byte = 8'h22;
    mem_read  = 1'b1; mem_read_idx  = 12'h301;
    tick();
    mem_write = 1'b0;
    mem_read  = 1'b0;
    check("raw_ack", {31'd0, mem_read_ack}, 32'd1);
    tick();
    read_mem(12'h301, 8'h22);

    // clear screen, load sprites
    for (int i = 0; i < 256; i++) write_mem(12'h100 + 12'(i), 8'h00);
    write_mem(12'h400, 8'hF0);
    write_mem(12'h410, 8'hFF);
    write_mem(12'h411, 8'hFF);

    // aligned single line, then XOR back off with collision
    run_draw(12'h400, 4'd1, 6'd0, 5'd0, 1'b0, 5);
    read_mem(12'h100, 8'hF0);
    run_draw(12'h400, 4'd1, 6'd0, 5'd0, 1'b1, 5);
    read_mem(12'h100, 8'h00);

    // lines=0: one busy cycle, collision cleared from the previous draw
    run_draw(12'h400, 4'd0, 6'd0, 5'd0, 1'b0, 1);
    read_mem(12'h100, 8'h00);

    // wrap in both axes: x=61 -> column 7, shift 5; FF>>5=07, FF<<3=F8
    run_draw(12'h410, 4'd2, 6'd61, 5'd31, 1'b0, 16);
    read_mem(12'h1FF, 8'h07);
    read_mem(12'h1F8, 8'hF8);
    read_mem(12'h107, 8'h07);
    read_mem(12'h100, 8'hF8);

    // external accesses and a second draw while busy are ignored
    coll_q.push_back(1'b0);
    dur_q.push_back(5);
    start_draw(12'h400, 4'd1, 6'd8, 5'd2);
    mem_write = 1'b1; mem_write_idx = 12'h111; mem_write_byte = 8'h55;
    mem_read  = 1'b1; mem_read_idx  = 12'h300;
    draw = 1'b1; addr = 12'h410; lines = 4'd15; x = 6'd3; y = 5'd9;
    tick();
    mem_write = 1'b0;
    mem_read  = 1'b0;
    draw      = 1'b0;
    check("ack_while_busy", {31'd0, mem_read_ack}, 32'd0);
    wait_idle();
    read_mem(12'h111, 8'hF0);
    read_mem(12'h300, 8'hA5);

    // reset in the middle of a colliding draw
    start_draw(12'h400, 4'd2, 6'd0, 5'd0);
    repeat (6) tick();
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    check("coll_before_reset", {31'd0, collision}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_collision", {31'd0, collision}, 32'd0);
    check("abort_ack", {31'd0, mem_read_ack}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_draw(12'h400, 4'd1, 6'd16, 5'd5, 1'b0, 5);
    read_mem(12'h12A, 8'hF0);
    read_mem(12'h100, 8'h08);

    repeat (3) tick();
    check("read_queue_empty", exp_q.size(), 32'd0);
    check("draw_queue_empty", coll_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
